// File: rtl/data_cache_pkg.sv
// Shared types, geometry defaults and byte-lane helpers for the L1 data cache.
package data_cache_pkg;

  localparam int unsigned DEF_SETS = 8;
  localparam int unsigned IDX_W    = $clog2(DEF_SETS);
  localparam int unsigned TAG_W    = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  // Load data: full word, or the addressed byte lane zero-extended.
  function automatic logic [31:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic        byte_op);
    logic [7:0] lane;
    lane = word[{offset, 3'b000} +: 8];
    return byte_op ? {24'h0, lane} : word;
  endfunction

  // Byte enables for a store merged into a line.
  function automatic logic [3:0] store_be(input logic [1:0] offset,
                                          input logic       byte_op);
    return byte_op ? (4'b0001 << offset) : 4'b1111;
  endfunction

  // Store data replicated so the enabled lane always carries wdata[7:0].
  function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                             input logic        byte_op);
    return byte_op ? {4{wdata[7:0]}} : wdata;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Memory-side bus of the data cache; master = cache, slave = main memory.
interface data_cache_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic                  mem_byte_op_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: asynchronous read by index, one synchronous
// byte-enabled write port; reset clears only the valid bits.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int unsigned SET_CNT  = DEF_SETS,
  parameter int unsigned IDX_BITS = IDX_W,
  parameter int unsigned TAG_BITS = TAG_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [3:0]          wr_be,
  input  logic [31:0]         wr_data
);

  logic [SET_CNT-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q  [SET_CNT];
  logic [31:0]         data_q [SET_CNT];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Line update: a write marks the line valid and (re)writes its tag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hits complete in the request cycle; misses and stores stall until ack.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SETS       = DEF_SETS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic                  byte_op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  data_cache_if.master          mem,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;

  state_t              state_q, state_d;
  logic [1:0]          offset;
  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                line_valid;
  logic [TAG_BITS-1:0] line_tag;
  logic [31:0]         line_data;
  logic                hit;
  logic                wr_en;
  logic [3:0]          wr_be;
  logic [31:0]         wr_data;
  logic                hit_inc, miss_inc;
  logic [31:0]         hit_cnt_q, miss_cnt_q;

  assign offset = addr_i[1:0];
  assign idx    = addr_i[IDX_BITS+1:2];
  assign tag    = addr_i[ADDR_WIDTH-1:IDX_BITS+2];
  assign hit    = line_valid && (line_tag == tag);

  data_cache_array #(
    .SET_CNT (SETS),
    .IDX_BITS(IDX_BITS),
    .TAG_BITS(TAG_BITS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rd_idx  (idx),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, core/memory outputs and line writes.
  always_comb begin
    state_d           = state_q;
    stall_o           = 1'b0;
    rdata_o           = '0;
    mem.mem_req_o     = 1'b0;
    mem.mem_we_o      = 1'b0;
    mem.mem_byte_op_o = 1'b0;
    mem.mem_addr_o    = '0;
    mem.mem_wdata_o   = '0;
    wr_en             = 1'b0;
    wr_be             = '0;
    wr_data           = '0;
    hit_inc           = 1'b0;
    miss_inc          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (we_i) begin
            stall_o = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            rdata_o = lane_select(line_data, offset, byte_op_i);
            hit_inc = 1'b1;
          end else begin
            stall_o  = 1'b1;
            miss_inc = 1'b1;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        if (mem.mem_ack_i) begin
          wr_en   = 1'b1;
          wr_be   = 4'b1111;
          wr_data = mem.mem_rdata_i;
          rdata_o = lane_select(mem.mem_rdata_i, offset, byte_op_i);
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      WRITE: begin
        mem.mem_req_o     = 1'b1;
        mem.mem_we_o      = 1'b1;
        mem.mem_byte_op_o = byte_op_i;
        mem.mem_addr_o    = addr_i;
        mem.mem_wdata_o   = wdata_i;
        if (mem.mem_ack_i) begin
          state_d = IDLE;
          if (hit) begin
            wr_en   = 1'b1;
            wr_be   = store_be(offset, byte_op_i);
            wr_data = store_data(wdata_i, byte_op_i);
          end
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating load hit/miss counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed scenarios followed by random
// loads/stores against a word-addressed memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req, we, byte_op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] hit_cnt, miss_cnt;

  data_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_bus ();

  data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .we_i      (we),
    .byte_op_i (byte_op),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .stall_o   (stall),
    .mem       (mem_bus),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- memory responder (environment) ----------------
  logic [31:0] bmem [int unsigned];
  int unsigned lat_cfg = 0;
  int unsigned cnt = 0;
  int unsigned req_cycles = 0;
  bit          spur = 1'b0;
  logic        cap_we, cap_bop;
  logic [31:0] cap_addr;

  initial begin
    mem_bus.mem_ack_i   = 1'b0;
    mem_bus.mem_rdata_i = '0;
    forever begin
      int unsigned wa;
      logic [31:0] w;
      @(posedge clk);
      #2;
      mem_bus.mem_ack_i = 1'b0;
      if (mem_bus.mem_req_o) begin
        req_cycles++;
        if (cnt == lat_cfg) begin
          cnt = 0;
          mem_bus.mem_ack_i = 1'b1;
          cap_we   = mem_bus.mem_we_o;
          cap_bop  = mem_bus.mem_byte_op_o;
          cap_addr = mem_bus.mem_addr_o;
          wa = mem_bus.mem_addr_o >> 2;
          w  = bmem.exists(wa) ? bmem[wa] : init_word(wa);
          if (mem_bus.mem_we_o) begin
            if (mem_bus.mem_byte_op_o)
              w[{mem_bus.mem_addr_o[1:0], 3'b000} +: 8] = mem_bus.mem_wdata_o[7:0];
            else
              w = mem_bus.mem_wdata_o;
            bmem[wa] = w;
          end else begin
            mem_bus.mem_rdata_i = w;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (spur) begin
          mem_bus.mem_ack_i = 1'b1;
          spur = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] rmem [int unsigned];
  bit          mvalid [8];
  int unsigned mtag [8];
  logic [31:0] hits = 0, misses = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] rread(input int unsigned wa);
    return rmem.exists(wa) ? rmem[wa] : init_word(wa);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    bmem[a >> 2] = v;
    rmem[a >> 2] = v;
  endtask

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    hits = 0;
    misses = 0;
  endtask

  // Scoreboard monitor: every completing load is compared against the queue.
  always @(negedge clk) begin
    if (rst_ni && req && !we && !stall) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL load_unexpected: got %h expected no completion at %0t", rdata, $time);
      end else begin
        chk("load_data", rdata, exp_q.pop_front());
      end
    end
  end

  // One core access; entered and left just after a rising edge.
  task automatic access(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input int unsigned lat);
    int unsigned wa, idx, tg, stalls, exp_stalls;
    bit          hit;
    logic [31:0] word;
    wa  = a >> 2;
    idx = wa % 8;
    tg  = a >> 5;
    hit = mvalid[idx] && (mtag[idx] == tg);
    word = rread(wa);
    if (w) begin
      if (b) begin
        int unsigned sh;
        sh = 8 * (a % 4);
        word = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else begin
        word = d;
      end
      rmem[wa] = word;
      exp_stalls = 1 + lat;
    end else begin
      exp_q.push_back(b ? ((word >> (8 * (a % 4))) & 32'hFF) : word);
      if (hit) begin
        if (hits != 32'hFFFF_FFFF) hits++;
        exp_stalls = 0;
      end else begin
        if (misses != 32'hFFFF_FFFF) misses++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        exp_stalls  = 1 + lat;
      end
    end
    req_cycles = 0;
    cap_we = 1'bx; cap_bop = 1'bx; cap_addr = 'x;
    lat_cfg = lat;
    req = 1'b1; we = w; byte_op = b; addr = a; wdata = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls > 500) begin
        vectors++;
        miscompares++;
        $display("FAIL stall_timeout: got %0d stalled cycles expected %0d", stalls, exp_stalls);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; byte_op = 1'b0;
    chk("stall_cycles", stalls, exp_stalls);
    chk("hit_cnt", hit_cnt, hits);
    chk("miss_cnt", miss_cnt, misses);
    if (w || !hit) begin
      chk("mem_req_cycles", req_cycles, 1 + lat);
      chk("mem_we", {31'b0, cap_we}, {31'b0, w});
      chk("mem_byte_op", {31'b0, cap_bop}, {31'b0, w & b});
      chk("mem_addr", cap_addr, w ? a : (a & 32'hFFFF_FFFC));
    end else begin
      chk("hit_no_mem_req", req_cycles, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    req = 1'b0; we = 1'b0; byte_op = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_mem_req", {31'b0, mem_bus.mem_req_o}, 0);
    chk("rst_mem_we", {31'b0, mem_bus.mem_we_o}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;

    // Fill, hit, byte store merge, byte/word loads after the store.
    preload(32'h100, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    access(1'b1, 1'b1, 32'h101, 32'h55, 2);
    access(1'b0, 1'b1, 32'h101, 32'h0, 1);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("merged_word_direct", rread(32'h40), 32'hDEAD_55EF);

    // Conflict eviction and store miss without allocation.
    access(1'b0, 1'b0, 32'h120, 32'h0, 1);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("conflict_miss_cnt", miss_cnt, 32'd3);
    access(1'b1, 1'b0, 32'h140, 32'h1234_5678, 1);
    access(1'b0, 1'b0, 32'h140, 32'h0, 0);

    // Reset while a fill is outstanding.
    lat_cfg = 1000;
    req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 32'h180;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    req = 1'b0; rst_ni = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_mem_req", {31'b0, mem_bus.mem_req_o}, 0);
    chk("abort_stall", {31'b0, stall}, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    chk("abort_rdata", rdata, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);

    // Counter saturation.
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.hit_cnt_q;
    hits = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 0);
    chk("hit_cnt_saturated", hit_cnt, 32'hFFFF_FFFF);

    // Spurious ack while idle.
    spur = 1'b1;
    @(negedge clk);
    chk("spur_ack_seen", {31'b0, mem_bus.mem_ack_i}, 1);
    chk("spur_stall", {31'b0, stall}, 0);
    chk("spur_mem_req", {31'b0, mem_bus.mem_req_o}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("spur_after_mem_req", {31'b0, mem_bus.mem_req_o}, 0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h102, 32'h0, 0);

    // Random traffic over 32 words spread across all sets.
    for (int n = 0; n < 300; n++) begin
      logic        rw, rb;
      logic [31:0] ra;
      rw = ($urandom_range(0, 2) == 0);
      rb = 1'($urandom_range(0, 1));
      ra = 32'h100 + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
      access(rw, rb, ra, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
